cmp_sar_search: RTL and testbench

Successive-approximation search engine: the querying end of the 2-bit magnitude-compare protocol. It drives 5-bit guesses toward a comparator that holds an unknown target. From the returned compare codes it recovers the target (range 0..15) in at most 5 probes, or flags an inconsistent or stalled responder. It sits between a control unit issuing `start` and any combinational or registered compare responder.

---
 rtl/cmp_pkg.sv | 21 ++
 rtl/cmp_wait_timer.sv | 27 ++
 rtl/cmp_sar_search.sv | 145 ++++++++++++++
 tb/tb_cmp_sar_search.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// cmp_pkg: shared compare codes, FSM states and error causes for the SAR search engine
package cmp_pkg;

    localparam logic [1:0] CMP_EQZ = 2'b00;
    localparam logic [1:0] CMP_GT  = 2'b01;
    localparam logic [1:0] CMP_LT  = 2'b10;
    localparam logic [1:0] CMP_EQ  = 2'b11;

    localparam logic [1:0] ERR_TIMEOUT = 2'b00;
    localparam logic [1:0] ERR_ZERO    = 2'b01;
    localparam logic [1:0] ERR_VERIFY  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROBE,
        S_VERIFY,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/cmp_wait_timer.sv
// cmp_wait_timer: counts stalled probe cycles and flags the edge on which the count reaches TIMEOUT
module cmp_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic expired
);

    logic [7:0] cnt;

    // expired fires during the stalled cycle whose edge would bring the count to TIMEOUT
    assign expired = count && (cnt == 8'(TIMEOUT - 1));

    // stall counter, restarted whenever a probe is accepted or none is pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (count)
            cnt <= cnt + 8'd1;
    end

endmodule

// File: rtl/cmp_sar_search.sv
// cmp_sar_search: successive-approximation search recovering a 4-bit target through compare probes
module cmp_sar_search
    import cmp_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [4:0] guess,
    output logic       guess_valid,
    input  logic [1:0] cmp_code,
    input  logic       cmp_valid,
    output logic       busy,
    output logic       done,
    output logic [4:0] result,
    output logic [2:0] steps,
    output logic       err,
    output logic [1:0] err_cause
);

    state_t     state, state_n;
    logic [3:0] acc, acc_n, nacc;
    logic [1:0] idx, idx_n;
    logic [2:0] steps_n;
    logic [4:0] guess_n, result_n;
    logic       done_n, err_n;
    logic [1:0] cause_n;
    logic       accept, expired;

    assign guess_valid = (state == S_PROBE) || (state == S_VERIFY);
    assign busy        = guess_valid;
    assign accept      = guess_valid && cmp_valid;
    assign nacc        = (cmp_code == CMP_GT) ? guess[3:0] : acc;

    cmp_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!guess_valid || accept),
        .count   (guess_valid && !cmp_valid),
        .expired (expired)
    );

    // next-state and datapath update for one probe decision per accept
    always_comb begin
        state_n  = state;
        acc_n    = acc;
        idx_n    = idx;
        steps_n  = steps;
        guess_n  = guess;
        result_n = result;
        done_n   = 1'b0;
        err_n    = err;
        cause_n  = err_cause;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_n = S_PROBE;
                    acc_n   = '0;
                    idx_n   = 2'd3;
                    steps_n = '0;
                    err_n   = 1'b0;
                    cause_n = ERR_TIMEOUT;
                    guess_n = 5'd8;
                end
            end
            S_PROBE: begin
                if (expired) begin
                    state_n = S_ERR;
                    err_n   = 1'b1;
                    cause_n = ERR_TIMEOUT;
                end else if (accept) begin
                    steps_n = steps + 3'd1;
                    if (cmp_code == CMP_EQ) begin
                        result_n = guess;
                        done_n   = 1'b1;
                        state_n  = S_DONE;
                    end else if (cmp_code == CMP_EQZ) begin
                        state_n = S_ERR;
                        err_n   = 1'b1;
                        cause_n = ERR_ZERO;
                    end else begin
                        acc_n = nacc;
                        if (idx != 2'd0) begin
                            idx_n   = idx - 2'd1;
                            guess_n = {1'b0, nacc | (4'd1 << (idx - 2'd1))};
                        end else if (nacc != 4'd0) begin
                            state_n = S_ERR;
                            err_n   = 1'b1;
                            cause_n = ERR_VERIFY;
                        end else begin
                            state_n = S_VERIFY;
                            guess_n = '0;
                        end
                    end
                end
            end
            S_VERIFY: begin
                if (expired) begin
                    state_n = S_ERR;
                    err_n   = 1'b1;
                    cause_n = ERR_TIMEOUT;
                end else if (accept) begin
                    steps_n = steps + 3'd1;
                    if (cmp_code == CMP_EQZ) begin
                        result_n = '0;
                        done_n   = 1'b1;
                        state_n  = S_DONE;
                    end else begin
                        state_n = S_ERR;
                        err_n   = 1'b1;
                        cause_n = ERR_VERIFY;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            acc       <= '0;
            idx       <= '0;
            steps     <= '0;
            guess     <= '0;
            result    <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_cause <= ERR_TIMEOUT;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            idx       <= idx_n;
            steps     <= steps_n;
            guess     <= guess_n;
            result    <= result_n;
            done      <= done_n;
            err       <= err_n;
            err_cause <= cause_n;
        end
    end

endmodule

// File: tb/tb_cmp_sar_search.sv
// tb_cmp_sar_search: table, random and hand-written checks of the SAR search engine against a responder model
module tb_cmp_sar_search;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] guess;
    logic       guess_valid;
    logic [1:0] cmp_code;
    logic       cmp_valid;
    logic       busy, done, err;
    logic [4:0] result;
    logic [2:0] steps;
    logic [1:0] err_cause;

    int checks = 0;
    int failures = 0;

    int         mode = 0;
    logic [1:0] fcode = 2'b00;
    int         tgt = 0;
    int         dly = 0;
    bit         resp_on = 1'b1;
    int         wcnt = 0;
    bit         acc_s = 1'b0, gv_s = 1'b0;
    bit         prev_gv = 1'b0, prev_acc = 1'b0;
    logic [4:0] prev_guess = '0;
    int         stab_err = 0;
    int         probes[$];
    int         exp_q[$];

    always #5 clk = ~clk;

    cmp_sar_search #(.TIMEOUT(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .guess       (guess),
        .guess_valid (guess_valid),
        .cmp_code    (cmp_code),
        .cmp_valid   (cmp_valid),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .steps       (steps),
        .err         (err),
        .err_cause   (err_cause)
    );

    assign cmp_code  = (mode == 1) ? fcode :
                       (tgt > int'(guess)) ? 2'b01 :
                       (tgt < int'(guess)) ? 2'b10 :
                       (tgt == 0) ? 2'b00 : 2'b11;
    assign cmp_valid = resp_on && guess_valid && (wcnt >= dly);

    // responder bookkeeping and probe log sampled mid-cycle
    always @(negedge clk) begin
        acc_s = guess_valid && cmp_valid;
        gv_s  = guess_valid;
        if (acc_s) probes.push_back(int'(guess));
        if (guess_valid && prev_gv && !prev_acc && guess !== prev_guess) stab_err++;
        prev_gv    = guess_valid;
        prev_acc   = acc_s;
        prev_guess = guess;
    end

    always @(posedge clk) wcnt <= (acc_s || !gv_s) ? 0 : wcnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
        end
    endtask

    function automatic int model_steps(input int t);
        int tz;
        if (t == 0) return 5;
        tz = 0;
        while (((t >> tz) & 1) == 0) tz++;
        return 4 - tz;
    endfunction

    task automatic model_probes(input int t);
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            int sh = 4 - k;
            int p = ((t >> sh) << sh) | (1 << (3 - k));
            exp_q.push_back(p);
            if (p == t) return;
        end
        exp_q.push_back(0);
    endtask

    task automatic run_check(input string nm, input int md, input logic [1:0] fc, input int t,
                             input int d, input int mid, input logic e_err, input logic [1:0] e_cause,
                             input logic [4:0] e_res, input int e_steps, input int e_lat);
        int lat = 0;
        bit fin = 1'b0;
        mode = md; fcode = fc; tgt = t; dly = d; resp_on = 1'b1;
        @(negedge clk);
        probes.delete();
        stab_err = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({nm, ".launch"}, {busy, guess_valid, guess, err}, {1'b1, 1'b1, 5'd8, 1'b0});
        for (int c = 1; c <= 400 && !fin; c++) begin
            if (c == mid) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            if (done || err) begin fin = 1'b1; lat = c; end
        end
        chk({nm, ".finished"}, fin, 1);
        chk({nm, ".latency"}, lat, e_lat);
        chk({nm, ".err"}, {err, err_cause}, {e_err, e_cause});
        chk({nm, ".steps"}, steps, e_steps);
        if (!e_err) begin
            chk({nm, ".result"}, result, e_res);
            @(posedge clk);
            #1 chk({nm, ".done_pulse"}, {done, busy, guess_valid}, 3'b000);
        end
        chk({nm, ".stable"}, stab_err, 0);
        if (md == 0) begin
            model_probes(t);
            chk({nm, ".nprobes"}, probes.size(), exp_q.size());
            for (int k = 0; k < exp_q.size() && k < probes.size(); k++)
                chk({nm, ".probe"}, probes[k], exp_q[k]);
        end
    endtask

    typedef struct {
        int         md;
        logic [1:0] fc;
        int         t;
        int         d;
        logic       e;
        logic [1:0] cause;
        logic [4:0] res;
        int         st;
        int         lat;
    } vec_t;

    vec_t vt[9];

    initial begin
        vt[0] = '{0, 2'b00, 11, 0, 1'b0, 2'b00, 5'd11, 4, 4};
        vt[1] = '{0, 2'b00,  0, 0, 1'b0, 2'b00, 5'd0,  5, 5};
        vt[2] = '{0, 2'b00,  6, 3, 1'b0, 2'b00, 5'd6,  3, 12};
        vt[3] = '{0, 2'b00, 15, 0, 1'b0, 2'b00, 5'd15, 4, 4};
        vt[4] = '{0, 2'b00,  8, 1, 1'b0, 2'b00, 5'd8,  1, 2};
        vt[5] = '{1, 2'b00,  0, 0, 1'b1, 2'b01, 5'd0,  1, 1};
        vt[6] = '{1, 2'b01,  0, 0, 1'b1, 2'b10, 5'd0,  4, 4};
        vt[7] = '{1, 2'b10,  0, 0, 1'b1, 2'b10, 5'd0,  5, 5};
        vt[8] = '{1, 2'b11,  0, 0, 1'b0, 2'b00, 5'd8,  1, 1};

        #3;
        chk("reset_outputs", {guess, guess_valid, busy, done, result, steps, err, err_cause},
            {5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 2'b00});
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vt[n])
            run_check($sformatf("vec%0d", n), vt[n].md, vt[n].fc, vt[n].t, vt[n].d, 0,
                      vt[n].e, vt[n].cause, vt[n].res, vt[n].st, vt[n].lat);

        for (int n = 0; n < 20; n++) begin
            int t = $urandom_range(0, 15);
            int d = $urandom_range(0, 4);
            int s = model_steps(t);
            run_check($sformatf("rand%0d", n), 0, 2'b00, t, d, 0, 1'b0, 2'b00, 5'(t), s, s * (d + 1));
        end

        run_check("mid_start", 0, 2'b00, 11, 2, 3, 1'b0, 2'b00, 5'd11, 4, 12);

        mode = 0; tgt = 8; dly = 0; resp_on = 1'b1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        chk("final_accept_start.done", {done, result}, {1'b1, 5'd8});
        @(posedge clk);
        #1 chk("final_accept_start.idle", {guess_valid, busy, done}, 3'b000);

        resp_on = 1'b0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (14) @(posedge clk);
        #1 chk("timeout.before", {err, guess_valid, guess}, {1'b0, 1'b1, 5'd8});
        @(posedge clk);
        #1 chk("timeout.at", {err, err_cause, guess_valid, busy}, {1'b1, 2'b00, 1'b0, 1'b0});
        @(posedge clk);
        #1 chk("timeout.sticky", {err, err_cause}, {1'b1, 2'b00});

        run_check("after_err", 0, 2'b00, 13, 1, 0, 1'b0, 2'b00, 5'd13, 4, 8);

        mode = 0; tgt = 5; dly = 3; resp_on = 1'b1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async_reset", {guess, guess_valid, busy, done, result, steps, err, err_cause},
               {5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 2'b00});
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("reset_no_resume", {guess_valid, done, busy}, 3'b000);

        run_check("post_reset", 0, 2'b00, 10, 0, 0, 1'b0, 2'b00, 5'd10, 3, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
